// File: rtl/ddr2axis_pkg.sv
// Shared FSM encoding, default frame geometry and helpers for the DDR frame reader.
package ddr2axis_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AR    = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Default geometry, matching the writer: 128-bit beats, 32-bit words, 16-beat bursts.
    localparam int unsigned BYTES_PER_BEAT = 16;
    localparam int unsigned RATIO          = 4;
    localparam int unsigned BURST_BYTES    = 256;
    localparam int unsigned FRAME_BURSTS   = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rd_fifo_sync.sv
// Single-clock FIFO with show-ahead read data and a free-entry count; DEPTH is a power of two.
module rd_fifo_sync
    import ddr2axis_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   free
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count;
    logic             full, wr_ok, rd_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign free    = FULL_CNT - count;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is not reset; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ddr2axis_rd.sv
// Reads a fixed-size frame from DDR in AXI4 bursts and replays it as an AXI4-Stream.
module ddr2axis_rd
    import ddr2axis_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h1000_0000,
    parameter int C_M_AXI_BURST_LEN    = BURST_BYTES / BYTES_PER_BEAT,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 8 * BYTES_PER_BEAT,
    parameter int C_M_AXIS_TDATA_WIDTH = 8 * BYTES_PER_BEAT / RATIO,
    parameter int C_FRAME_BEATS        = FRAME_BURSTS * C_M_AXI_BURST_LEN
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              start,
    output logic                              busy,
    output logic                              rd_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TUSER,
    input  logic                              M_AXIS_TREADY
);
    localparam int BEAT_BYTES  = C_M_AXI_DATA_WIDTH / 8;
    localparam int WORDS       = C_M_AXI_DATA_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int STRIDE      = C_M_AXI_BURST_LEN * BEAT_BYTES;
    localparam int NUM_BURSTS  = C_FRAME_BEATS / C_M_AXI_BURST_LEN;
    localparam int FRAME_WORDS = C_FRAME_BEATS * WORDS;
    localparam int FIFO_DEPTH  = 2 * C_M_AXI_BURST_LEN;
    localparam int FREE_W      = clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W      = clog2(C_M_AXI_BURST_LEN) + 1;
    localparam int BURST_W     = clog2(NUM_BURSTS) + 1;
    localparam int WORD_W      = clog2(FRAME_WORDS) + 1;
    localparam int LANE_W      = (WORDS > 1) ? clog2(WORDS) : 1;

    logic [1:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [BURST_W-1:0]            burst_idx_q;
    logic [BEAT_W-1:0]             beat_cnt_q;
    logic [WORD_W-1:0]             word_cnt_q;
    logic                          rd_err_q;
    logic                          unp_valid_q;
    logic [LANE_W-1:0]             lane_q;
    logic [WORDS-1:0][C_M_AXIS_TDATA_WIDTH-1:0] unp_data_q;

    logic                          start_acc, ar_hs, r_hs, t_hs, burst_done, last_burst;
    logic                          unp_take, load, bypass, fifo_empty;
    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_rdata, load_data;
    logic [FREE_W-1:0]             fifo_free;
    logic                          unused_rid;

    assign unused_rid = ^M_AXI_RID;

    assign start_acc  = start && (state_q == ST_IDLE);
    assign ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;
    assign t_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
    // Completion is counted in beats; RLAST only qualifies the final beat.
    assign burst_done = r_hs && M_AXI_RLAST && (beat_cnt_q == BEAT_W'(C_M_AXI_BURST_LEN - 1));
    assign last_burst = (burst_idx_q == BURST_W'(NUM_BURSTS - 1));

    // An empty unpacker takes a beat straight off the R channel when the FIFO is empty.
    assign unp_take  = !unp_valid_q || (t_hs && (lane_q == LANE_W'(WORDS - 1)));
    assign load      = unp_take && (!fifo_empty || r_hs);
    assign bypass    = load && fifo_empty;
    assign load_data = fifo_empty ? M_AXI_RDATA : fifo_rdata;

    rd_fifo_sync #(
        .WIDTH (C_M_AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .wr_en   (r_hs && !bypass),
        .wr_data (M_AXI_RDATA),
        .rd_en   (load && !fifo_empty),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_AR;
            ST_AR:    if (ar_hs) state_d = ST_RD;
            ST_RD:    if (burst_done) state_d = last_burst ? ST_DRAIN : ST_AR;
            ST_DRAIN: if (t_hs && M_AXIS_TLAST && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            araddr_q    <= C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            word_cnt_q  <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                araddr_q    <= C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);
                burst_idx_q <= '0;
                beat_cnt_q  <= '0;
                word_cnt_q  <= '0;
                rd_err_q    <= 1'b0;
            end else begin
                if (burst_done) begin
                    beat_cnt_q  <= '0;
                    burst_idx_q <= burst_idx_q + 1'b1;
                    if (!last_burst) araddr_q <= araddr_q + C_M_AXI_ADDR_WIDTH'(STRIDE);
                end else if (r_hs) begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
                if (r_hs && (M_AXI_RRESP != 2'b00)) rd_err_q <= 1'b1;
                if (t_hs) word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            unp_valid_q <= 1'b0;
            lane_q      <= '0;
            unp_data_q  <= '0;
        end else if (load) begin
            unp_valid_q <= 1'b1;
            lane_q      <= '0;
            unp_data_q  <= load_data;
        end else if (t_hs) begin
            if (lane_q == LANE_W'(WORDS - 1)) begin
                unp_valid_q <= 1'b0;
                lane_q      <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign rd_err        = rd_err_q;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'(clog2(BEAT_BYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0010;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    // Space for a whole burst is reserved before the address goes out.
    assign M_AXI_ARVALID = (state_q == ST_AR) && (fifo_free >= FREE_W'(C_M_AXI_BURST_LEN));
    assign M_AXI_RREADY  = (state_q == ST_RD);

    assign M_AXIS_TVALID = unp_valid_q;
    assign M_AXIS_TDATA  = unp_data_q[lane_q];
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TUSER  = unp_valid_q && (word_cnt_q == '0);
    assign M_AXIS_TLAST  = unp_valid_q && (word_cnt_q == WORD_W'(FRAME_WORDS - 1));

endmodule

// File: tb/tb_ddr2axis_rd.sv
// Bench for ddr2axis_rd: memory-backed AXI read slave, stream scoreboard and directed frames.
module tb_ddr2axis_rd;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, busy, rd_err;
    logic [0:0]   arid, rid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, rresp;
    logic         arlock, arvalid, arready;
    logic [3:0]   arcache, arqos, tstrb;
    logic [127:0] rdata;
    logic         rlast, rvalid, rready;
    logic         tvalid, tlast, tuser, tready;
    logic [31:0]  tdata;

    ddr2axis_rd dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .busy          (busy),
        .rd_err        (rd_err),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARLOCK  (arlock),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARQOS   (arqos),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RID     (rid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TUSER  (tuser),
        .M_AXIS_TREADY (tready)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame memory: 32-bit word k at byte address BASE + 4k.
    logic [31:0] mem [256];

    int          ar_delay = 0;
    int          err_beat = -1;
    bit          bp_mode  = 1'b0;
    int          ar_count, beats_rx, words_rx, bubbles;
    logic [31:0] ar_log [$];
    logic [31:0] first_tdata, last_tdata;

    // AXI read slave: one burst at a time, RVALID continuous during a burst.
    initial begin : slave
        logic        s_arv, s_arhs, s_rhs, p_pending, burst_on;
        logic [31:0] s_addr, burst_addr, first_addr;
        logic [7:0]  s_len;
        logic [2:0]  s_size;
        logic [1:0]  s_burst, s_rresp;
        logic [3:0]  s_cache;
        int          beat, ar_wait, k0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = '0;
        burst_on = 0; p_pending = 0; ar_wait = 0; beat = 0; burst_addr = BASE; first_addr = BASE;
        forever begin
            @(negedge clk);
            s_arv = arvalid; s_arhs = arvalid && arready; s_rhs = rvalid && rready;
            s_addr = araddr; s_len = arlen; s_size = arsize; s_burst = arburst;
            s_cache = arcache; s_rresp = rresp;
            if (rst_n) begin
                if (p_pending) check("arvalid_not_withdrawn", arvalid, 1);
                if (burst_on) check("rready_held_in_burst", rready, 1);
                if (s_arv) check("ar_only_with_space", (beats_rx - words_rx / 4) <= 17, 1);
                if (s_rhs && s_rresp != 2'b00) check("rd_err_before_error", rd_err, 0);
            end
            p_pending = s_arv && !s_arhs;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
                burst_on = 0; p_pending = 0; ar_wait = 0;
                continue;
            end
            if (s_arhs) begin
                check("araddr", s_addr, BASE + 32'(ar_count) * 32'h100);
                check("arlen", s_len, 15);
                check("arsize", s_size, 4);
                check("arburst", s_burst, 1);
                check("arcache", s_cache, 2);
                ar_log.push_back(s_addr);
                ar_count++;
                arready = 0; ar_wait = 0;
                burst_on = 1; beat = 0; burst_addr = s_addr;
            end else if (s_arv) begin
                if (ar_wait > 0) check("araddr_stable", s_addr, first_addr);
                else first_addr = s_addr;
                ar_wait++;
                if (ar_wait > ar_delay) arready = 1;
            end
            if (s_rhs) begin
                if (beats_rx == 0) check("first_word_latency", tvalid, 1);
                if (s_rresp != 2'b00) check("rd_err_set", rd_err, 1);
                beats_rx++;
                beat++;
            end
            if (burst_on && beat == 16) begin
                burst_on = 0; rvalid = 0; rlast = 0; rresp = 0;
            end else if (burst_on && (s_arhs || s_rhs)) begin
                k0 = int'((burst_addr - BASE) >> 2) + 4 * beat;
                rdata  = {mem[k0 + 3], mem[k0 + 2], mem[k0 + 1], mem[k0]};
                rlast  = (beat == 15);
                rresp  = (beats_rx == err_beat) ? 2'b10 : 2'b00;
                rvalid = 1;
            end
        end
    end

    initial begin : sink
        tready = 1;
        forever begin
            @(posedge clk);
            #1;
            tready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Stream scoreboard: word i of a frame must carry mem[i], TUSER on 0, TLAST on 255.
    initial begin : compare
        logic        p_tv, p_tr, p_user, p_last, done_pending;
        logic [31:0] p_data;
        p_tv = 0; p_tr = 0; p_user = 0; p_last = 0; p_data = '0; done_pending = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_tv = 0; done_pending = 0;
                continue;
            end
            if (done_pending) check("busy_falls_after_tlast", busy, 0);
            done_pending = 0;
            if (p_tv && !p_tr) begin
                check("hold_tvalid", tvalid, 1);
                check("hold_tdata", tdata, p_data);
                check("hold_tuser", tuser, p_user);
                check("hold_tlast", tlast, p_last);
            end
            if (tvalid && tready) begin
                check("word_in_frame", words_rx < 256, 1);
                check("tdata", tdata, (words_rx < 256) ? mem[words_rx] : 32'hffff_ffff);
                check("tuser", tuser, words_rx == 0);
                check("tlast", tlast, words_rx == 255);
                check("tstrb", tstrb, 4'hf);
                if (words_rx == 0) first_tdata = tdata;
                if (words_rx == 255) begin
                    last_tdata = tdata;
                    done_pending = 1;
                end
                words_rx++;
            end else if (!tvalid && words_rx > 0 && words_rx < 256) begin
                bubbles++;
            end
            p_tv = tvalid; p_tr = tready; p_data = tdata; p_user = tuser; p_last = tlast;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_tuser"}, tuser, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_err"}, rd_err, 0);
        check({tag, "_araddr"}, araddr, 32'h1000_0000);
    endtask

    task automatic start_frame(input bit poke_start);
        beats_rx = 0; words_rx = 0; ar_count = 0; bubbles = 0;
        ar_log.delete();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        check("busy_after_start", busy, 1);
        check("arvalid_after_start", arvalid, 1);
        check("rd_err_cleared_by_start", rd_err, 0);
        if (poke_start) begin
            for (int i = 0; i < 3000 && words_rx < 50; i++) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check({tag, "_frame_done"}, busy, 0);
        check({tag, "_word_count"}, words_rx, 256);
        check({tag, "_ar_count"}, ar_count, 4);
    endtask

    initial begin : main
        for (int k = 0; k < 256; k++) mem[k] = 32'(k);
        rst_n = 0; start = 0;
        repeat (10) @(posedge clk);
        #1 check_reset_outputs("reset");
        check("reset_arlen", arlen, 15);
        @(negedge clk) rst_n = 1;

        // Plain frame, TREADY always high.
        start_frame(0);
        finish_frame("plain");
        check("plain_no_bubbles", bubbles, 0);
        check("plain_rd_err", rd_err, 0);
        for (int i = 0; i < 4; i++)
            check("ar_addr_literal", (ar_log.size() > i) ? ar_log[i] : 32'hffff_ffff,
                  32'h1000_0000 + 32'(i) * 32'h100);
        check("first_word_literal", first_tdata, 32'h0);
        check("last_word_literal", last_tdata, 32'hff);

        // Random 30% TREADY backpressure.
        bp_mode = 1;
        start_frame(0);
        finish_frame("backpressure");
        bp_mode = 0;

        // Slow ARREADY.
        ar_delay = 5;
        start_frame(0);
        finish_frame("ar_delay");
        ar_delay = 0;

        // SLVERR on beat 20, plus a start pulse while busy that must be ignored.
        err_beat = 20;
        start_frame(1);
        finish_frame("error");
        check("rd_err_sticky", rd_err, 1);
        err_beat = -1;

        // Reset in the middle of a frame, then a fresh frame.
        start_frame(0);
        for (int i = 0; i < 3000 && words_rx < 100; i++) @(posedge clk);
        #2 rst_n = 0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1;
        start_frame(0);
        finish_frame("after_reset");
        check("after_reset_first_word", first_tdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
